// File: rtl/bf_pkg.sv
// Shared Brainfuck definitions: opcode encoding, loader error causes and the
// ASCII-to-opcode encoder used by the program loader.
package bf_pkg;

    typedef enum logic [2:0] {
        P = 3'd0,
        M = 3'd1,
        R = 3'd2,
        L = 3'd3,
        O = 3'd4,
        I = 3'd5,
        J = 3'd6,
        K = 3'd7
    } t_instr;

    typedef enum logic [1:0] {
        TOO_LONG        = 2'd0,
        TOO_DEEP        = 2'd1,
        UNMATCHED_CLOSE = 2'd2,
        UNCLOSED_OPEN   = 2'd3
    } t_load_err;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        JMP2 = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } t_load_state;

    typedef struct packed {
        logic   is_bf;
        t_instr instr;
    } t_decode;

    localparam logic [7:0] ASCII_PLUS   = 8'h2B;
    localparam logic [7:0] ASCII_MINUS  = 8'h2D;
    localparam logic [7:0] ASCII_GT     = 8'h3E;
    localparam logic [7:0] ASCII_LT     = 8'h3C;
    localparam logic [7:0] ASCII_DOT    = 8'h2E;
    localparam logic [7:0] ASCII_COMMA  = 8'h2C;
    localparam logic [7:0] ASCII_LBRACK = 8'h5B;
    localparam logic [7:0] ASCII_RBRACK = 8'h5D;

    // Any byte outside the eight BF characters is a comment (is_bf=0).
    function automatic t_decode ascii_to_instr(input logic [7:0] c);
        t_decode d;
        d.is_bf = 1'b1;
        d.instr = P;
        case (c)
            ASCII_PLUS:   d.instr = P;
            ASCII_MINUS:  d.instr = M;
            ASCII_GT:     d.instr = R;
            ASCII_LT:     d.instr = L;
            ASCII_DOT:    d.instr = O;
            ASCII_COMMA:  d.instr = I;
            ASCII_LBRACK: d.instr = J;
            ASCII_RBRACK: d.instr = K;
            default:      d.is_bf = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/bf_program_loader_if.sv
// Loader bus: source character stream in, program/jump memory writes and
// completion status out.
interface bf_program_loader_if #(
    parameter int PROGRAM_LENGTH = 256
);
    localparam int PA = $clog2(PROGRAM_LENGTH);
    localparam int LW = $clog2(PROGRAM_LENGTH + 1);

    logic [7:0]    src_char;
    logic          src_valid;
    logic          src_last;
    logic          src_ready;
    logic          prog_we;
    logic [PA-1:0] prog_addr;
    logic [2:0]    prog_data;
    logic          jmp_we;
    logic [PA-1:0] jmp_addr;
    logic [PA-1:0] jmp_data;
    logic          done;
    logic          error;
    logic [1:0]    err_code;
    logic [LW-1:0] prog_len;

    modport master (
        output src_char, src_valid, src_last,
        input  src_ready, prog_we, prog_addr, prog_data,
        input  jmp_we, jmp_addr, jmp_data,
        input  done, error, err_code, prog_len
    );

    modport slave (
        input  src_char, src_valid, src_last,
        output src_ready, prog_we, prog_addr, prog_data,
        output jmp_we, jmp_addr, jmp_data,
        output done, error, err_code, prog_len
    );
endinterface

// File: rtl/bf_bracket_stack.sv
// LIFO of open-bracket addresses; top is the most recent push.
module bf_bracket_stack #(
    parameter int DEPTH = 15,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    sp_q, sp_d;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (sp_q == CW'(DEPTH));
    assign empty   = (sp_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign wr_idx  = AW'(sp_q);
    assign rd_idx  = AW'(sp_q - 1'b1);
    assign top     = empty ? '0 : mem_q[rd_idx];

    always_comb begin
        mem_d = mem_q;
        sp_d  = sp_q;
        if (push_ok) begin
            mem_d[wr_idx] = push_data;
            sp_d          = sp_q + 1'b1;
        end else if (pop_ok) begin
            sp_d = sp_q - 1'b1;
        end
    end

    // Entries are don't-care once popped, so only the pointer is reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

endmodule

// File: rtl/bf_program_loader.sv
// Encodes a streamed BF source into opcode memory and builds the matched
// bracket jump table, validating balance, nesting depth and length.
module bf_program_loader
    import bf_pkg::*;
#(
    parameter int PROGRAM_LENGTH = 256,
    parameter int MAX_DEPTH      = 15
) (
    input logic clk,
    input logic rst,
    bf_program_loader_if.slave bus
);
    localparam int PA = $clog2(PROGRAM_LENGTH);
    localparam int LW = $clog2(PROGRAM_LENGTH + 1);

    t_load_state   state_q, state_d;
    logic [LW-1:0] wp_q, wp_d;
    logic [PA-1:0] jmp_open_q, jmp_open_d;
    logic [PA-1:0] jmp_close_q, jmp_close_d;
    logic          last_q, last_d;
    t_load_err     err_code_q, err_code_d;
    logic          prog_we_q, prog_we_d;
    logic [PA-1:0] prog_addr_q, prog_addr_d;
    logic [2:0]    prog_data_q, prog_data_d;
    logic          jmp_we_q, jmp_we_d;
    logic [PA-1:0] jmp_addr_q, jmp_addr_d;
    logic [PA-1:0] jmp_data_q, jmp_data_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic          src_ready;
    logic          accept;
    t_decode       dec;
    logic          is_open;
    logic          is_close;
    logic          err_long;
    logic          err_deep;
    logic          err_close;
    logic          bf_err;
    logic          bf_write;
    t_load_err     err_sel;
    logic          last_ok;
    logic [PA-1:0] stk_top;
    logic          stk_full;
    logic          stk_empty;

    assign src_ready = (state_q == LOAD) && !rst;
    assign accept    = bus.src_valid && src_ready;
    assign dec       = ascii_to_instr(bus.src_char);
    assign is_open   = dec.is_bf && (dec.instr == J);
    assign is_close  = dec.is_bf && (dec.instr == K);

    assign err_long  = (wp_q == LW'(PROGRAM_LENGTH));
    assign err_deep  = is_open && stk_full;
    assign err_close = is_close && stk_empty;
    assign bf_err    = accept && dec.is_bf && (err_long || err_deep || err_close);
    assign bf_write  = accept && dec.is_bf && !(err_long || err_deep || err_close);
    assign err_sel   = err_long ? TOO_LONG : (err_deep ? TOO_DEEP : UNMATCHED_CLOSE);
    // Depth after a non-']' last character: an accepted '[' makes it nonzero.
    assign last_ok   = stk_empty && !is_open;

    bf_bracket_stack #(
        .DEPTH (MAX_DEPTH),
        .WIDTH (PA)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (bf_write && is_open),
        .pop       (bf_write && is_close),
        .push_data (PA'(wp_q)),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            wp_q        <= '0;
            jmp_open_q  <= '0;
            jmp_close_q <= '0;
            last_q      <= 1'b0;
            err_code_q  <= TOO_LONG;
            prog_we_q   <= 1'b0;
            prog_addr_q <= '0;
            prog_data_q <= '0;
            jmp_we_q    <= 1'b0;
            jmp_addr_q  <= '0;
            jmp_data_q  <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            jmp_open_q  <= jmp_open_d;
            jmp_close_q <= jmp_close_d;
            last_q      <= last_d;
            err_code_q  <= err_code_d;
            prog_we_q   <= prog_we_d;
            prog_addr_q <= prog_addr_d;
            prog_data_q <= prog_data_d;
            jmp_we_q    <= jmp_we_d;
            jmp_addr_q  <= jmp_addr_d;
            jmp_data_q  <= jmp_data_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wp_d        = wp_q;
        jmp_open_d  = jmp_open_q;
        jmp_close_d = jmp_close_q;
        last_d      = last_q;
        err_code_d  = err_code_q;
        case (state_q)
            LOAD: begin
                if (bf_err) begin
                    state_d    = ERR;
                    err_code_d = err_sel;
                end else if (accept) begin
                    if (bf_write) begin
                        wp_d = wp_q + 1'b1;
                    end
                    if (bf_write && is_close) begin
                        // Second half of the table entry is written from JMP2.
                        state_d     = JMP2;
                        jmp_open_d  = stk_top;
                        jmp_close_d = PA'(wp_q);
                        last_d      = bus.src_last;
                    end else if (bus.src_last) begin
                        if (last_ok) begin
                            state_d = DONE;
                        end else begin
                            state_d    = ERR;
                            err_code_d = UNCLOSED_OPEN;
                        end
                    end
                end
            end
            JMP2: begin
                if (!last_q) begin
                    state_d = LOAD;
                end else if (stk_empty) begin
                    state_d = DONE;
                end else begin
                    state_d    = ERR;
                    err_code_d = UNCLOSED_OPEN;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        prog_we_d   = bf_write;
        prog_addr_d = bf_write ? PA'(wp_q) : prog_addr_q;
        prog_data_d = bf_write ? dec.instr : prog_data_q;
        jmp_we_d    = (bf_write && is_close) || (state_q == JMP2);
        jmp_addr_d  = jmp_addr_q;
        jmp_data_d  = jmp_data_q;
        if (state_q == JMP2) begin
            jmp_addr_d = jmp_open_q;
            jmp_data_d = jmp_close_q;
        end else if (bf_write && is_close) begin
            jmp_addr_d = PA'(wp_q);
            jmp_data_d = stk_top;
        end
        done_d  = done_q || (state_q == DONE);
        error_d = error_q || bf_err || (state_q == ERR);
    end

    assign bus.src_ready = src_ready;
    assign bus.prog_we   = prog_we_q;
    assign bus.prog_addr = prog_addr_q;
    assign bus.prog_data = prog_data_q;
    assign bus.jmp_we    = jmp_we_q;
    assign bus.jmp_addr  = jmp_addr_q;
    assign bus.jmp_data  = jmp_data_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.err_code  = err_code_q;
    assign bus.prog_len  = wp_q;

endmodule

// File: tb/tb_bf_program_loader.sv
// Randomized and directed source streams checked against a behavioural
// model through a write scoreboard.
module tb_bf_program_loader;
    localparam int PLEN = 256;
    localparam int MAXD = 15;

    typedef byte bq_t[$];
    typedef struct {
        int addr;
        int data;
        int rdy;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    wr_t  prog_q[$];
    wr_t  jmp_q[$];
    wr_t  mon_p;
    wr_t  mon_j;
    int   exp_done, exp_err, exp_code, exp_len, exp_consumed;

    byte  alpha[12] = '{8'h2B, 8'h2D, 8'h3E, 8'h3C, 8'h2E, 8'h2C,
                        8'h5B, 8'h5D, 8'h61, 8'h20, 8'h0A, 8'h23};

    bf_program_loader_if #(.PROGRAM_LENGTH(PLEN)) bus ();

    bf_program_loader #(
        .PROGRAM_LENGTH (PLEN),
        .MAX_DEPTH      (MAXD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_wr(input string name, input int a, input int d, input int r, input wr_t e);
        n_cmp++;
        if (a != e.addr || d != e.data || r != e.rdy) begin
            n_bad++;
            $display("FAIL %s: got addr=%0d data=%0d ready=%0d required addr=%0d data=%0d ready=%0d",
                     name, a, d, r, e.addr, e.data, e.rdy);
        end
    endtask

    // Scoreboard monitor: every write strobe pops one expected write.
    always @(negedge clk) begin
        if (bus.prog_we) begin
            if (prog_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL prog_write: got addr=%0d data=%0d required no write",
                         bus.prog_addr, bus.prog_data);
            end else begin
                mon_p = prog_q.pop_front();
                check_wr("prog_write", int'(bus.prog_addr), int'(bus.prog_data), int'(bus.src_ready), mon_p);
            end
        end
        if (bus.jmp_we) begin
            if (jmp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL jmp_write: got addr=%0d data=%0d required no write",
                         bus.jmp_addr, bus.jmp_data);
            end else begin
                mon_j = jmp_q.pop_front();
                check_wr("jmp_write", int'(bus.jmp_addr), int'(bus.jmp_data), int'(bus.src_ready), mon_j);
            end
        end
    end

    function automatic int op_of(input byte c);
        case (c)
            8'h2B: return 0;
            8'h2D: return 1;
            8'h3E: return 2;
            8'h3C: return 3;
            8'h2E: return 4;
            8'h2C: return 5;
            8'h5B: return 6;
            8'h5D: return 7;
            default: return -1;
        endcase
    endfunction

    function automatic bq_t to_q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Reference model: walks the source once, queueing the expected writes
    // and the final outcome.
    task automatic build(input bq_t p, input bit last_end);
        int wp;
        int a;
        int op;
        bit lst;
        int stk[$];
        wp = 0;
        exp_done = 0; exp_err = 0; exp_code = 0; exp_consumed = 0;
        for (int i = 0; i < p.size(); i++) begin
            lst = last_end && (i == p.size() - 1);
            op  = op_of(p[i]);
            exp_consumed = i + 1;
            if (op >= 0) begin
                if (wp == PLEN) begin exp_err = 1; exp_code = 0; break; end
                if (op == 6 && stk.size() == MAXD) begin exp_err = 1; exp_code = 1; break; end
                if (op == 7 && stk.size() == 0) begin exp_err = 1; exp_code = 2; break; end
                prog_q.push_back('{wp, op, (op != 7 && !lst) ? 1 : 0});
                if (op == 6) stk.push_back(wp);
                if (op == 7) begin
                    a = stk.pop_back();
                    jmp_q.push_back('{wp, a, 0});
                    jmp_q.push_back('{a, wp, lst ? 0 : 1});
                end
                wp++;
            end
            if (lst) begin
                if (stk.size() != 0) begin exp_err = 1; exp_code = 3; end
                else exp_done = 1;
            end
        end
        exp_len = wp;
    endtask

    task automatic send(input byte c, input bit last, output bit ok);
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) begin @(posedge clk); #1; end
        bus.src_char  = c;
        bus.src_last  = last;
        bus.src_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.src_ready) begin ok = 1'b1; break; end
            if (bus.done || bus.error) break;
        end
        if (!ok && !(bus.done || bus.error)) check("ready_timeout", 0, 1);
        @(posedge clk); #1;
        bus.src_valid = 1'b0;
        bus.src_last  = 1'b0;
    endtask

    task automatic do_reset();
        bus.src_valid = 1'b0;
        bus.src_last  = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        prog_q.delete();
        jmp_q.delete();
    endtask

    task automatic run_program(input string name, input bq_t p, input bit last_end);
        int acc;
        bit ok;
        build(p, last_end);
        acc = 0;
        for (int i = 0; i < p.size(); i++) begin
            if (bus.done || bus.error) break;
            send(p[i], last_end && (i == p.size() - 1), ok);
            if (!ok) break;
            acc++;
        end
        check({name, ".consumed"}, acc, exp_consumed);
        for (int k = 0; k < 30 && !(bus.done || bus.error); k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check({name, ".done"}, int'(bus.done), exp_done);
        check({name, ".error"}, int'(bus.error), exp_err);
        if (exp_err != 0) check({name, ".err_code"}, int'(bus.err_code), exp_code);
        check({name, ".prog_len"}, int'(bus.prog_len), exp_len);
        check({name, ".src_ready_end"}, int'(bus.src_ready), 0);
        check({name, ".prog_left"}, prog_q.size(), 0);
        check({name, ".jmp_left"}, jmp_q.size(), 0);
        $display("run %s: chars=%0d len=%0d done=%0d error=%0d code=%0d",
                 name, p.size(), bus.prog_len, bus.done, bus.error, bus.err_code);
        do_reset();
    endtask

    function automatic bq_t rand_prog(input bit balanced);
        bq_t q;
        int n;
        int depth;
        int r;
        n = $urandom_range(1, 30);
        depth = 0;
        for (int i = 0; i < n; i++) begin
            if (!balanced) begin
                q.push_back(alpha[$urandom_range(0, 11)]);
            end else begin
                r = $urandom_range(0, 9);
                if (r >= 8 && depth > 0) begin q.push_back(8'h5D); depth--; end
                else if (r >= 6 && depth < MAXD) begin q.push_back(8'h5B); depth++; end
                else begin
                    r = $urandom_range(0, 9);
                    q.push_back(alpha[(r < 6) ? r : r + 2]);
                end
            end
        end
        while (depth > 0) begin q.push_back(8'h5D); depth--; end
        return q;
    endfunction

    initial begin
        bq_t p;
        bit ok;
        bus.src_char  = 8'h00;
        bus.src_valid = 1'b0;
        bus.src_last  = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset.src_ready", int'(bus.src_ready), 0);
        check("reset.prog_we", int'(bus.prog_we), 0);
        check("reset.jmp_we", int'(bus.jmp_we), 0);
        check("reset.done", int'(bus.done), 0);
        check("reset.error", int'(bus.error), 0);
        check("reset.prog_len", int'(bus.prog_len), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset.src_ready_after", int'(bus.src_ready), 1);
        @(posedge clk); #1;

        run_program("nested", to_q("+[,[.-]+]"), 1'b1);
        run_program("comments", to_q("a+ b\n-"), 1'b1);
        run_program("unmatched", to_q("+]"), 1'b1);
        run_program("unclosed", to_q("[["), 1'b1);
        run_program("empty", to_q("xy"), 1'b1);
        p.delete();
        repeat (MAXD + 1) p.push_back(8'h5B);
        run_program("too_deep", p, 1'b1);
        p.delete();
        repeat (PLEN) p.push_back(8'h2B);
        run_program("full_len", p, 1'b1);
        p.push_back(8'h2B);
        run_program("too_long", p, 1'b1);

        // Reset during the JMP2 stall of "+[-]", then a fresh load.
        build(to_q("+[-]"), 1'b0);
        p = to_q("+[-]");
        for (int i = 0; i < p.size(); i++) send(p[i], 1'b0, ok);
        rst = 1'b1;
        @(negedge clk);
        check("midrst.src_ready", int'(bus.src_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst.prog_we", int'(bus.prog_we), 0);
        check("midrst.jmp_we", int'(bus.jmp_we), 0);
        check("midrst.prog_len", int'(bus.prog_len), 0);
        check("midrst.done", int'(bus.done), 0);
        check("midrst.src_ready_after", int'(bus.src_ready), 1);
        prog_q.delete();
        jmp_q.delete();
        @(posedge clk); #1;
        run_program("reload", to_q("-"), 1'b1);

        for (int t = 0; t < 30; t++) begin
            run_program($sformatf("rand%0d", t), rand_prog(t[0]), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
